mult_dispatcher: RTL and testbench

- Operand-feeding and result-collecting front end for the sequential signed multiplier (start/done handshake, q_in/m_in operands, mult_out product).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues each pair to the multiplier with a one-cycle start pulse, waits for done, then captures the product.
- Presents each product on a valid/ready result stream and flags a sticky error if the multiplier never answers.

---
 rtl/mult_dispatcher.sv | 171 +++++++++++++++++
 tb/tb_mult_dispatcher.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_dispatcher.sv
// mult_dispatcher: buffers signed operand pairs in a small FIFO, issues them one
// at a time to a start/done sequential multiplier, and returns each product on a
// valid/ready result stream. A multiplier that never answers is abandoned after
// TIMEOUT wait cycles and recorded in a sticky error flag.
module mult_dispatcher #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 31
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_q,
  input  logic [WIDTH-1:0]   in_m,
  output logic               start,
  output logic [WIDTH-1:0]   q_out,
  output logic [WIDTH-1:0]   m_out,
  input  logic               done,
  input  logic [2*WIDTH-1:0] mult_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_data,
  output logic               busy,
  output logic               timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT);
  localparam logic [PW:0]   PTR_FULL = {1'b1, {PW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_mem [DEPTH];
  logic [PW:0]          r_wr_ptr;
  logic [PW:0]          r_rd_ptr;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_q_out;
  logic [WIDTH-1:0]     r_m_out;
  logic [2*WIDTH-1:0]   r_res_data;
  logic                 r_res_valid;
  logic                 r_timeout_err;
  logic                 r_done_q;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_done_rise;
  logic                 w_capture;
  logic                 w_timeout;
  logic                 w_cnt_clr;
  logic                 w_cnt_inc;
  logic                 w_res_clr;
  logic                 w_start;
  logic [2*WIDTH-1:0]   w_head;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = ((r_wr_ptr ^ r_rd_ptr) == PTR_FULL);
  assign w_push      = in_valid & ~w_full;
  assign w_done_rise = done & ~r_done_q;
  assign w_head      = r_mem[r_rd_ptr[PW-1:0]];

  assign in_ready    = ~w_full;
  assign start       = w_start;
  assign q_out       = r_q_out;
  assign m_out       = r_m_out;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != S_IDLE) | ~w_empty;

  // FIFO storage write port.
  // NOTE: the storage array has no reset; emptiness is defined by the pointers,
  // so clearing the pointers already discards every entry.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= {in_q, in_m};
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control decode; start is a Moore output of ISSUE.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_res_clr   = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_start     = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done edge on the final wait cycle still wins over the timeout.
        if (w_done_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = S_OUT;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          w_res_clr   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: FIFO pointers, issued operands, wait counter, result and error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_cnt         <= '0;
      r_q_out       <= '0;
      r_m_out       <= '0;
      r_res_data    <= '0;
      r_res_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_done_q      <= 1'b0;
    end else begin
      r_done_q <= done;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_q_out  <= w_head[2*WIDTH-1:WIDTH];
        r_m_out  <= w_head[WIDTH-1:0];
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_ONE;
      if (w_capture) begin
        r_res_data  <= mult_in;
        r_res_valid <= 1'b1;
      end else if (w_res_clr) begin
        r_res_valid <= 1'b0;
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_dispatcher.sv
// Directed bench for mult_dispatcher with a behavioural start/done multiplier.
module tb_mult_dispatcher;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_q = '0;
  logic [3:0]   in_m = '0;
  logic         start;
  logic [3:0]   q_out;
  logic [3:0]   m_out;
  logic         done = 1'b0;
  logic [7:0]   mult_in = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [7:0]   res_data;
  logic         busy;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  mult_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_m(in_m),
    .start(start), .q_out(q_out), .m_out(m_out),
    .done(done), .mult_in(mult_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Multiplier model: done rises lat negedges after the start cycle; lat=0 never answers.
  int              lat = 0;
  int              m_cnt = 0;
  logic signed [7:0] m_prod;
  always @(negedge clock or posedge reset) begin
    if (reset) begin
      done  = 1'b0;
      m_cnt = 0;
    end else if (start) begin
      done   = 1'b0;
      m_cnt  = lat;
      m_prod = $signed(q_out) * $signed(m_out);
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        done    = 1'b1;
        mult_in = m_prod;
      end
    end
  end

  // Monitor at mid-cycle: start pulses, accepted pushes, delivered results.
  int         start_cnt = 0;
  int         start_run = 0;
  int         max_run = 0;
  int         acc_cnt = 0;
  logic [7:0] res_q[$];
  always @(negedge clock) begin
    if (start) begin
      start_cnt++;
      start_run++;
      if (start_run > max_run) max_run = start_run;
    end else begin
      start_run = 0;
    end
    if (in_valid && in_ready) acc_cnt++;
    if (res_valid && res_ready) res_q.push_back(res_data);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] q, input logic [3:0] m);
    in_valid = 1'b1;
    in_q     = q;
    in_m     = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k;
    k = 0;
    while (res_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (res_q.size() < n) begin
      errors++;
      $display("FAIL wait_results got %0d results required %0d", res_q.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", start); end
    checks++; if (q_out !== 4'h0) begin errors++; $display("FAIL rst_q_out got %h exp 0", q_out); end
    checks++; if (m_out !== 4'h0) begin errors++; $display("FAIL rst_m_out got %h exp 0", m_out); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL rst_res_data got %h exp 00", res_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got %b exp 0", timeout_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    reset = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL post_rst_idle got busy=%b start=%b exp 0 0", busy, start); end
  endtask

  // (6,-3), multiplier answers 4 cycles after start; result held until res_ready.
  task automatic test_single();
    int s0, k;
    s0 = start_cnt;
    lat = 4;
    res_ready = 1'b0;
    push(4'd6, 4'hD);
    k = 0;
    while (!res_valid && k < 20) begin
      tick();
      k++;
      if (!res_valid) begin
        checks++;
        if (q_out !== 4'd6 || m_out !== 4'hD) begin
          errors++; $display("FAIL single_operands cyc %0d got q=%h m=%h exp 6 d", k, q_out, m_out);
        end
      end
    end
    checks++; if (k !== 6) begin errors++; $display("FAIL single_latency got %0d exp 6", k); end
    checks++; if (res_data !== 8'hEE) begin errors++; $display("FAIL single_res_data got %h exp ee", res_data); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_starts got %0d exp 1", start_cnt - s0); end
    repeat (3) tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 8'hEE) begin errors++; $display("FAIL single_hold got v=%b d=%h exp 1 ee", res_valid, res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_res_clear got %b exp 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy); end
    checks++; if (res_q.size() !== 1) begin errors++; $display("FAIL single_delivered got %0d exp 1", res_q.size()); end
  endtask

  // Four pairs pushed on consecutive edges with a ready consumer.
  task automatic test_back_to_back();
    logic [7:0] exp_v[4];
    logic [7:0] got;
    int s0;
    exp_v = '{8'h40, 8'h31, 8'hC8, 8'h00};
    res_q.delete();
    s0 = start_cnt;
    max_run = 0;
    lat = 2;
    res_ready = 1'b1;
    push(4'h8, 4'h8);
    push(4'h7, 4'h7);
    push(4'h8, 4'h7);
    push(4'h0, 4'h5);
    wait_results(4, 100);
    for (int i = 0; i < 4; i++) begin
      got = (i < res_q.size()) ? res_q[i] : 8'hxx;
      checks++; if (got !== exp_v[i]) begin errors++; $display("FAIL b2b_result%0d got %h exp %h", i, got, exp_v[i]); end
    end
    checks++; if (start_cnt - s0 !== 4) begin errors++; $display("FAIL b2b_starts got %0d exp 4", start_cnt - s0); end
    checks++; if (max_run !== 1) begin errors++; $display("FAIL b2b_start_width got %0d exp 1", max_run); end
    res_ready = 1'b0;
  endtask

  // Consumer stalled: 4 buffered plus 1 in flight before in_ready drops.
  task automatic test_fifo_full();
    logic [7:0] got;
    int a0;
    res_q.delete();
    a0 = acc_cnt;
    lat = 1;
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_q = 4'(i + 1);
      in_m = 4'd2;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (acc_cnt - a0 !== 5) begin errors++; $display("FAIL full_accepted got %0d exp 5", acc_cnt - a0); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
    res_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_c1 got %b exp 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_c2 got %b exp 1", in_ready); end
    wait_results(5, 100);
    for (int i = 0; i < 5; i++) begin
      got = (i < res_q.size()) ? res_q[i] : 8'hxx;
      checks++; if (got !== 8'(2 * (i + 1))) begin errors++; $display("FAIL full_result%0d got %h exp %h", i, got, 8'(2 * (i + 1))); end
    end
    res_ready = 1'b0;
  endtask

  // done rises on the wait cycle where the counter equals TIMEOUT: done wins.
  task automatic test_timeout_edge();
    res_q.delete();
    lat = 32;
    res_ready = 1'b1;
    push(4'd3, 4'd5);
    wait_results(1, 80);
    checks++; if (res_q.size() < 1 || res_q[0] !== 8'h0F) begin errors++; $display("FAIL edge_result got %0d entries exp one 0f", res_q.size()); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL edge_timeout_err got %b exp 0", timeout_err); end
    res_ready = 1'b0;
  endtask

  // Silent multiplier: error on the 32nd wait cycle, next pair still served.
  task automatic test_timeout();
    int s0, k;
    res_q.delete();
    s0 = start_cnt;
    lat = 0;
    res_ready = 1'b1;
    push(4'd2, 4'd2);
    push(4'hF, 4'd3);
    k = 0;
    while (!start && k < 10) begin
      tick();
      k++;
    end
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL to_start_seen got %b exp 1", start); end
    repeat (32) tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", timeout_err); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", timeout_err); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL to_res_valid got %b exp 0", res_valid); end
    lat = 3;
    wait_results(1, 40);
    checks++; if (res_q.size() < 1 || res_q[0] !== 8'hFD) begin errors++; $display("FAIL to_next_result got %0d entries exp one fd", res_q.size()); end
    checks++; if (start_cnt - s0 !== 2) begin errors++; $display("FAIL to_starts got %0d exp 2", start_cnt - s0); end
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", timeout_err); end
    res_ready = 1'b0;
  endtask

  // Reset while waiting with two pairs queued discards everything.
  task automatic test_reset_mid();
    int s0;
    lat = 0;
    res_ready = 1'b0;
    push(4'd1, 4'd1);
    push(4'd2, 4'd2);
    push(4'd3, 4'd3);
    repeat (4) tick();
    checks++; if (busy !== 1'b1 || q_out !== 4'd1) begin errors++; $display("FAIL mid_pre got busy=%b q=%h exp 1 1", busy, q_out); end
    #2 reset = 1'b1;
    #1;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL mid_start got %b exp 0", start); end
    checks++; if (q_out !== 4'h0 || m_out !== 4'h0) begin errors++; $display("FAIL mid_operands got q=%h m=%h exp 0 0", q_out, m_out); end
    checks++; if (res_valid !== 1'b0 || res_data !== 8'h00) begin errors++; $display("FAIL mid_result got v=%b d=%h exp 0 00", res_valid, res_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL mid_timeout_err got %b exp 0", timeout_err); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_busy_ready got busy=%b rdy=%b exp 0 1", busy, in_ready); end
    tick();
    reset = 1'b0;
    res_q.delete();
    s0 = start_cnt;
    lat = 2;
    res_ready = 1'b1;
    repeat (20) tick();
    checks++; if (start_cnt - s0 !== 0 || res_q.size() !== 0) begin errors++; $display("FAIL mid_after got starts=%0d results=%0d exp 0 0", start_cnt - s0, res_q.size()); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_after_idle got busy=%b rdy=%b exp 0 1", busy, in_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_timeout_edge();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
